// File: rtl/seven_seg_scanner_if.sv
// Display bus between the datapath (master) and the seven-segment scanner (slave).
// The master supplies the packed hex value, the load strobe and the decimal point
// requests. The slave returns the active-low segment, decimal point and digit
// enable pins, plus the frame_done pulse.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   digit_an;
    logic                    frame_done;

    modport master (
        output value, load, dp_in,
        input  seg, dp, digit_an, frame_done
    );

    modport slave (
        input  value, load, dp_in,
        output seg, dp, digit_an, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner.
// - A load strobe captures value/dp_in into a staging register.
// - The staging register is copied to the shadow register only at a frame
//   boundary, so a single frame never mixes old and new digits.
// - Each digit slot starts with GHOST_CYC cycles in which every anode is off.
//   This lets the segment bus settle before the next digit is enabled.
// Optional feature: define SEVEN_SEG_LZB_EN to blank leading zeros.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GHOST_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ON   = PRESC_W'(GHOST_CYC);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [PRESC_W-1:0]    presc_r, presc_nxt_s;
    logic [SLOT_W-1:0]     slot_r, slot_nxt_s;
    logic                  slot_end_s, boundary_s;
    logic [VAL_W-1:0]      stage_val_r, shadow_val_r, shadow_val_nxt_s;
    logic [NUM_DIGITS-1:0] stage_dp_r, shadow_dp_r, shadow_dp_nxt_s;
    logic [3:0]            nibble_s;
    logic                  blank_s;
    logic [6:0]            seg_nxt_s, seg_r;
    logic                  dp_nxt_s, dp_r;
    logic [NUM_DIGITS-1:0] an_nxt_s, an_r;
    logic                  frame_done_r;

`ifdef SEVEN_SEG_LZB_EN
    logic [NUM_DIGITS-1:0] blank_r;

    // Digits above the most significant nonzero nibble; digit 0 is never flagged
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [VAL_W-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  lead;
        m    = {NUM_DIGITS{1'b0}};
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead = lead && (v[4*k +: 4] == 4'h0);
            m[k] = lead;
        end
        return m;
    endfunction
`endif

    // Next prescaler/slot values and frame boundary detection
    always_comb begin
        slot_end_s = (presc_r == PRESC_LAST);
        boundary_s = slot_end_s && (slot_r == SLOT_LAST);
        if (slot_end_s) begin
            presc_nxt_s = {PRESC_W{1'b0}};
            if (slot_r == SLOT_LAST) begin
                slot_nxt_s = {SLOT_W{1'b0}};
            end else begin
                slot_nxt_s = slot_r + SLOT_W'(1);
            end
        end else begin
            presc_nxt_s = presc_r + PRESC_W'(1);
            slot_nxt_s  = slot_r;
        end
    end

    // Shadow update at the frame boundary; a load on that same cycle bypasses staging
    always_comb begin
        if (boundary_s) begin
            if (bus.load) begin
                shadow_val_nxt_s = bus.value;
                shadow_dp_nxt_s  = bus.dp_in;
            end else begin
                shadow_val_nxt_s = stage_val_r;
                shadow_dp_nxt_s  = stage_dp_r;
            end
        end else begin
            shadow_val_nxt_s = shadow_val_r;
            shadow_dp_nxt_s  = shadow_dp_r;
        end
    end

    // Segment/dp pattern for the current slot and anode pattern for the next cycle
    always_comb begin
        nibble_s = shadow_val_r[{slot_r, 2'b00} +: 4];
`ifdef SEVEN_SEG_LZB_EN
        blank_s  = blank_r[slot_r];
`else
        blank_s  = 1'b0;
`endif
        if (blank_s) begin
            seg_nxt_s = 7'h7F;
        end else begin
            seg_nxt_s = seg_decode(nibble_s);
        end
        dp_nxt_s = ~shadow_dp_r[slot_r];
        an_nxt_s = {NUM_DIGITS{1'b1}};
        if (presc_nxt_s >= PRESC_ON) begin
            an_nxt_s[slot_nxt_s] = 1'b0;
        end else begin
            an_nxt_s = {NUM_DIGITS{1'b1}};
        end
    end

    // Scan timing state: prescaler and slot index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PRESC_W{1'b0}};
            slot_r  <= {SLOT_W{1'b0}};
        end else begin
            presc_r <= presc_nxt_s;
            slot_r  <= slot_nxt_s;
        end
    end

    // Staging register: the last load before a boundary wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_val_r <= {VAL_W{1'b0}};
            stage_dp_r  <= {NUM_DIGITS{1'b0}};
        end else if (bus.load) begin
            stage_val_r <= bus.value;
            stage_dp_r  <= bus.dp_in;
        end
    end

    // Shadow register: the value shown for the whole current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_r <= {VAL_W{1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
        end else begin
            shadow_val_r <= shadow_val_nxt_s;
            shadow_dp_r  <= shadow_dp_nxt_s;
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    // Leading-zero mask, captured alongside the shadow value at each boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_r <= {NUM_DIGITS{1'b0}};
        end else if (boundary_s) begin
            blank_r <= lzb_mask(shadow_val_nxt_s);
        end
    end
`endif

    // Registered pins: seg/dp change only at slot start, while the anodes are still off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            an_r         <= {NUM_DIGITS{1'b1}};
            frame_done_r <= 1'b0;
        end else begin
            if (presc_r == {PRESC_W{1'b0}}) begin
                seg_r <= seg_nxt_s;
                dp_r  <= dp_nxt_s;
            end
            an_r         <= an_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.digit_an   = an_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits sharing one segment bus. It latches a packed hex value, decodes one nibble per scan slot to active-low segments, and rotates the active-low digit enables at a programmable refresh rate. Display updates take effect only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the datapath (counters, register readback) and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- CLK_DIV, 50000, clock cycles per digit slot (>= GHOST_CYC+2)
- GHOST_CYC, 2, cycles at the start of each slot with all digit enables off (anti-ghosting)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  packed hex value; nibble k (value[4k+3:4k]) is digit k, digit 0 rightmost
- load  in  1  single-cycle strobe; captures value and dp_in into the staging register
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- dp  out  1  decimal point, active-low, registered
- digit_an  out  NUM_DIGITS  digit enables, active-low, one-cold or all-high, registered
- frame_done  out  1  one-cycle pulse when the last slot of a frame ends

## Operation
- Prescaler counts 0..CLK_DIV-1, wraps; at CLK_DIV-1 the slot index advances k -> k+1, N-1 -> 0.
- Frame boundary = prescaler at CLK_DIV-1 with slot index NUM_DIGITS-1; frame_done pulses on the following cycle.
- load: staging <= {value, dp_in}; a later load before the boundary overwrites the earlier one (last wins).
- At the frame boundary: shadow <= staging. If load coincides with the boundary cycle, shadow takes the new value/dp_in directly (bypass).
- Decode of shadow nibble k in slot k, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- digit_an[k]=0 only when prescaler >= GHOST_CYC in slot k; otherwise all ones. seg/dp update at the slot start so they are stable before the anode turns on.
- dp = ~shadow_dp[k].
- Reset (async, rst_n=0): prescaler 0, slot 0, staging 0, shadow 0, seg=7'h7F, dp=1, digit_an all ones, frame_done=0. Reset mid-frame aborts immediately; a pending staged value is lost.

## Timing
- Outputs registered: slot k segment pattern is valid from cycle 1 of slot k; anode on from cycle GHOST_CYC to CLK_DIV-1 of the slot.
- load-to-display latency: up to one full frame (NUM_DIGITS*CLK_DIV cycles) plus 1.
- Refresh per digit = f_clk / (NUM_DIGITS*CLK_DIV).
- NUM_DIGITS=1: every slot end is a frame boundary; frame_done pulses every CLK_DIV cycles.
- No input handshake; load is accepted every cycle.

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking. At each boundary, digits above the most significant nonzero nibble are flagged blank; a blank digit drives seg=7'h7F, and its dp is lit only if requested. Digit 0 is never blanked (value 0 shows "0").
- Undefined: every digit is always decoded; no blanking logic is present.

## Test plan
- Reset with NUM_DIGITS=4, CLK_DIV=4, GHOST_CYC=1: hold rst_n=0 -> seg=7F, dp=1, digit_an=1111; release -> slot 0 shows 1000000, digit_an=1110 from cycle 1.
- load value=16'h12AF, dp_in=4'b0100 -> after the next boundary, slots 0..3 show F=0001110, A=0001000, 2=0100100, 1=1111001; dp=0 only in slot 2.
- Two loads (16'h1111 then 16'h2222) within one frame -> next frame shows 2222 only; load coincident with boundary -> the value appears in the immediately following frame.
- Anode timing: per slot, digit_an all ones for GHOST_CYC cycles then one-cold; frame_done pulses once every 16 cycles.
- With SEVEN_SEG_LZB_EN: load 16'h0050 -> digits 3,2 blank (7F), digit 1 = 0010010, digit 0 = 1000000; load 0 -> only digit 0 lit as "0".
- rst_n asserted mid-slot 2 after a pending load -> outputs go to reset values asynchronously; after release, display shows 0000 (the staged value is discarded).
